// File: rtl/vga_fetch_pkg.sv
// Shared definitions for the frame-buffer fetch scheduler.
//   fetch_state_e  : request FSM states (idle, request on bus, draining a stale request)
//   *_DEF          : default geometry of the 640x480 monochrome frame buffer
//   word_byte()    : pick one byte out of a 32-bit frame-buffer word
package vga_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    localparam int C_ADDR_BITS_DEF   = 30;
    localparam int C_FIFO_LOG2_DEF   = 4;
    localparam int C_FRAME_WORDS_DEF = 9600;   // 640*480 pixels / 8 per byte / 4 per word
    localparam int BYTES_PER_WORD    = 4;

    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] sel);
        return w[{sel, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/vga_fetch_fifo.sv
// Synchronous word FIFO between the memory bus and the byte unpacker.
//   clk_i, reset_i : clock, synchronous active-high reset
//   flush_i        : empty the FIFO (frame restart)
//   push_i/wdata_i : write one word (caller guarantees not full)
//   pop_i          : drop the head word (caller guarantees not empty)
//   head_o, next_o : head word and the word behind it (lets the caller look one pop ahead)
//   count_o        : words held, empty_o : count_o == 0
module vga_fetch_fifo
    import vga_fetch_pkg::*;
#(
    parameter int C_fifo_log2 = C_FIFO_LOG2_DEF
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [31:0]            wdata_i,
    output logic [31:0]            head_o,
    output logic [31:0]            next_o,
    output logic [C_fifo_log2:0]   count_o,
    output logic                   empty_o
);
    localparam int DEPTH = 1 << C_fifo_log2;

    logic [31:0]            mem_q [DEPTH];
    logic [C_fifo_log2-1:0] wptr_q, rptr_q, rptr_nx;
    logic [C_fifo_log2:0]   count_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage carries no reset: contents are only visible through count_q.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rptr_nx = rptr_q + 1'b1;
    assign head_o  = mem_q[rptr_q];
    assign next_o  = mem_q[rptr_nx];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/vga_fetch_ctrl.sv
// Frame-buffer fetch scheduler: reads 32-bit words over the CPU-clock bus,
// buffers them and hands the display one byte per rd pulse. Restarts on vsync.
//   clk_i, reset_i   : clock, synchronous active-high reset
//   enable_i         : allow new memory requests
//   base_addr_i      : frame-buffer word address, taken at frame restart
//   mem_strobe_o     : request valid (held until mem_ack_i)
//   mem_addr_o       : word address of the request
//   mem_ack_i        : one-cycle acknowledge, mem_data_i valid with it
//   rd_i             : display consumed the current byte
//   vsync_n_i        : asynchronous active-low vsync from the pixel domain
//   disp_data_o      : current byte for the display (registered)
//   underrun_o       : sticky, rd seen with FIFO empty; cleared at frame restart
module vga_fetch_ctrl
    import vga_fetch_pkg::*;
#(
    parameter int C_addr_bits   = C_ADDR_BITS_DEF,
    parameter int C_fifo_log2   = C_FIFO_LOG2_DEF,
    parameter int C_frame_words = C_FRAME_WORDS_DEF
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic [C_addr_bits-1:0] base_addr_i,
    output logic                   mem_strobe_o,
    output logic [C_addr_bits-1:0] mem_addr_o,
    input  logic                   mem_ack_i,
    input  logic [31:0]            mem_data_i,
    input  logic                   rd_i,
    input  logic                   vsync_n_i,
    output logic [7:0]             disp_data_o,
    output logic                   underrun_o
);
    localparam int                   CW          = $clog2(C_frame_words + 1);
    localparam logic [CW-1:0]        FRAME_WORDS = CW'(C_frame_words);
    localparam logic [C_fifo_log2:0] FIFO_DEPTH  = {1'b1, {C_fifo_log2{1'b0}}};
    localparam logic [C_fifo_log2:0] CNT_ONE     = {{C_fifo_log2{1'b0}}, 1'b1};
    localparam logic [1:0]           LAST_SEL    = 2'(BYTES_PER_WORD - 1);

    fetch_state_e           state_q, state_d;
    logic [C_addr_bits-1:0] addr_q, addr_d, base_q, base_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [1:0]             sel_q, sel_d;
    logic [7:0]             disp_q, disp_d;
    logic                   und_q, und_d;
    logic [2:0]             vs_q;          // [1:0] synchroniser, [2] edge history

    logic                   frame_start, push, pop, empty_n;
    logic [31:0]            head, nxt, head_n;
    logic [C_fifo_log2:0]   fifo_count;
    logic                   fifo_empty;

    assign frame_start = vs_q[2] & ~vs_q[1];
    // A restart discards anything that completes in the same cycle.
    assign push = (state_q == ST_REQ) && mem_ack_i && !frame_start;
    assign pop  = rd_i && !frame_start && !fifo_empty && (sel_q == LAST_SEL);

    vga_fetch_fifo #(.C_fifo_log2(C_fifo_log2)) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (frame_start),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (mem_data_i),
        .head_o  (head),
        .next_o  (nxt),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        und_d   = und_q;
        disp_d  = 8'h00;
        head_n  = head;
        empty_n = 1'b1;

        case (state_q)
            ST_IDLE: begin
                // At most one request in flight, so a free slot now stays free.
                if (!frame_start && enable_i && cnt_q < FRAME_WORDS && fifo_count < FIFO_DEPTH)
                    state_d = ST_REQ;
            end
            ST_REQ: begin
                if (mem_ack_i) begin
                    state_d = ST_IDLE;
                    addr_d  = addr_q + 1'b1;
                end else if (frame_start) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (mem_ack_i) begin
                    state_d = ST_IDLE;
                    addr_d  = base_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (push) cnt_d = cnt_q + 1'b1;

        if (frame_start) begin
            base_d = base_addr_i;
            cnt_d  = '0;
            sel_d  = '0;
            und_d  = 1'b0;
            // The bus address may only move when nothing is outstanding or the
            // outstanding request completes now; otherwise DRAIN reloads base_q.
            if (state_q == ST_IDLE || mem_ack_i) addr_d = base_addr_i;
        end else begin
            if (rd_i) begin
                if (fifo_empty) und_d = 1'b1;
                else            sel_d = sel_q + 1'b1;
            end
            // disp_data shows the byte the FIFO head will present after this edge.
            if (fifo_empty)
                head_n = mem_data_i;
            else if (pop)
                head_n = (fifo_count == CNT_ONE) ? mem_data_i : nxt;
            empty_n = (fifo_empty || (pop && fifo_count == CNT_ONE)) && !push;
            disp_d  = empty_n ? 8'h00 : word_byte(head_n, sel_d);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            disp_q  <= 8'h00;
            und_q   <= 1'b0;
            vs_q    <= '1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            disp_q  <= disp_d;
            und_q   <= und_d;
            vs_q    <= {vs_q[1:0], vsync_n_i};
        end
    end

    assign mem_strobe_o = (state_q != ST_IDLE);
    assign mem_addr_o   = addr_q;
    assign disp_data_o  = disp_q;
    assign underrun_o   = und_q;

endmodule

// File: tb/tb_vga_fetch_ctrl.sv
// Bench for vga_fetch_ctrl: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vga_fetch_ctrl;
    localparam int AW    = 30;
    localparam int NW    = 9600;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset, enable, mem_strobe, mem_ack, rd, vsync_n, underrun;
    logic [AW-1:0] base_addr, mem_addr;
    logic [31:0]   mem_data;
    logic [7:0]    disp_data;

    always #5 clk = ~clk;

    vga_fetch_ctrl dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .enable_i     (enable),
        .base_addr_i  (base_addr),
        .mem_strobe_o (mem_strobe),
        .mem_addr_o   (mem_addr),
        .mem_ack_i    (mem_ack),
        .mem_data_i   (mem_data),
        .rd_i         (rd),
        .vsync_n_i    (vsync_n),
        .disp_data_o  (disp_data),
        .underrun_o   (underrun)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- memory responder ----------------
    bit ack_on     = 1;
    int ack_dly    = 0;
    bit data_fixed = 1;

    initial begin : responder
        int wait_cnt;
        wait_cnt = 0;
        mem_ack  = 1'b0;
        mem_data = 32'h0;
        forever begin
            tick();
            if (mem_ack) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (mem_strobe && ack_on) begin
                if (wait_cnt >= ack_dly) begin
                    mem_ack  = 1'b1;
                    mem_data = data_fixed ? 32'h44332211 : $urandom;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // ---------------- ack monitor ----------------
    int            acks = 0;
    logic [AW-1:0] first_addr [2];
    logic [AW-1:0] last_addr;

    always @(negedge clk) begin
        if (mem_ack && mem_strobe) begin
            if (acks < 2) first_addr[acks] = mem_addr;
            acks++;
            last_addr = mem_addr;
        end
    end

    // ---------------- reference model ----------------
    // Words on their way to the display live in a queue; m_sel is the byte
    // being shown; m_busy/m_stale tell whether a request is on the bus and
    // whether its data is to be thrown away.
    logic [31:0]   mq [$];
    int            m_sel, m_words;
    bit            m_busy, m_stale, m_und;
    logic [AW-1:0] m_addr, m_base;
    logic [7:0]    m_disp;
    bit   [2:0]    m_vs;

    always @(posedge clk) begin : model
        int n0;
        bit fs, start;
        if (reset) begin
            mq.delete();
            m_sel = 0; m_words = 0; m_busy = 0; m_stale = 0; m_und = 0;
            m_addr = '0; m_base = '0; m_disp = 8'h00; m_vs = 3'b111;
        end else begin
            fs   = m_vs[2] && !m_vs[1];   // synchronised vsync went 1 -> 0
            m_vs = {m_vs[1:0], vsync_n};
            n0   = mq.size();
            if (fs) begin
                if ((m_busy || m_stale) && !mem_ack) begin
                    m_busy = 0; m_stale = 1;
                end else begin
                    m_busy = 0; m_stale = 0; m_addr = base_addr;
                end
                m_base = base_addr;
                mq.delete();
                m_sel = 0; m_words = 0; m_und = 0;
            end else begin
                start = !m_busy && !m_stale && enable && m_words < NW && n0 < DEPTH;
                if (m_busy && mem_ack) begin
                    mq.push_back(mem_data);
                    m_words++;
                    m_addr = m_addr + 1'b1;
                    m_busy = 0;
                end else if (m_stale && mem_ack) begin
                    m_stale = 0;
                    m_addr  = m_base;
                end
                if (rd) begin
                    if (n0 == 0) m_und = 1;
                    else if (m_sel == 3) begin
                        void'(mq.pop_front());
                        m_sel = 0;
                    end else m_sel++;
                end
                if (start) m_busy = 1;
            end
            m_disp = (mq.size() == 0) ? 8'h00 : 8'(mq[0] >> (8 * m_sel));
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("strobe",   {31'b0, mem_strobe}, {31'b0, m_busy || m_stale});
            check("addr",     {2'b0, mem_addr},    {2'b0, m_addr});
            check("disp",     {24'b0, disp_data},  {24'b0, m_disp});
            check("underrun", {31'b0, underrun},   {31'b0, m_und});
        end
    end

    // ---------------- stimulus ----------------
    task automatic vs_pulse();
        vsync_n = 1'b0;
        repeat (4) tick();
        vsync_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic wait_strobe(input logic lvl, input string name);
        int i;
        for (i = 0; i < 40; i++) begin
            if (mem_strobe === lvl) break;
            tick();
        end
        if (i == 40) check(name, {31'b0, mem_strobe}, {31'b0, lvl});
    endtask

    initial begin : stim
        logic [7:0]    exp_b [8];
        logic [AW-1:0] a0;
        int            vs_low;
        exp_b = '{8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

        reset = 1'b1; enable = 1'b0; rd = 1'b0; vsync_n = 1'b1; base_addr = 30'h100;
        tick();
        cmp_on = 1;
        tick();
        check("rst_strobe",   {31'b0, mem_strobe}, 32'h0);
        check("rst_addr",     {2'b0, mem_addr},    32'h0);
        check("rst_disp",     {24'b0, disp_data},  32'h0);
        check("rst_underrun", {31'b0, underrun},   32'h0);
        reset = 1'b0;

        // 1: fill the FIFO from base 0x100, no reads
        vs_pulse();
        check("restart_addr", {2'b0, mem_addr}, 32'h100);
        acks = 0;
        enable = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (acks >= 16 && !mem_strobe) break;
        end
        repeat (10) tick();
        check("fill_acks",   acks, 16);
        check("fill_first",  {2'b0, first_addr[0]}, 32'h100);
        check("fill_second", {2'b0, first_addr[1]}, 32'h101);
        check("fill_strobe", {31'b0, mem_strobe}, 32'h0);
        check("fill_next",   {2'b0, mem_addr}, 32'h110);
        check("fill_disp",   {24'b0, disp_data}, 32'h11);

        // 2: byte unpack, rd every 8 clocks
        for (int k = 0; k < 8; k++) begin
            rd = 1'b1;
            tick();
            rd = 1'b0;
            check("unpack_byte", {24'b0, disp_data}, {24'b0, exp_b[k]});
            repeat (7) tick();
        end

        // 3: full frame with prompt acks
        enable = 1'b0;
        repeat (4) tick();
        acks = 0; data_fixed = 0; ack_dly = 0; base_addr = 30'h2000;
        vs_pulse();
        enable = 1'b1; rd = 1'b1;
        for (int i = 0; i < 60000; i++) begin
            tick();
            if (acks >= NW && !mem_strobe) break;
        end
        repeat (20) tick();
        rd = 1'b0;
        check("frame_acks",   acks, NW);
        check("frame_last",   {2'b0, last_addr}, 32'h2000 + NW - 1);
        check("frame_strobe", {31'b0, mem_strobe}, 32'h0);

        // 4: restart while a request is on the bus
        data_fixed = 1; ack_dly = 5; base_addr = 30'h300;
        vs_pulse();
        repeat (20) tick();
        wait_strobe(1'b0, "t4_wait_low");
        wait_strobe(1'b1, "t4_wait_high");
        a0 = mem_addr;
        base_addr = 30'h555;
        vsync_n = 1'b0;
        repeat (3) tick();
        vsync_n = 1'b1;
        check("drain_strobe", {31'b0, mem_strobe}, 32'h1);
        check("drain_addr",   {2'b0, mem_addr}, {2'b0, a0});
        check("drain_flush",  {24'b0, disp_data}, 32'h0);
        wait_strobe(1'b0, "t4_drain_done");
        check("drain_nopush", {24'b0, disp_data}, 32'h0);
        wait_strobe(1'b1, "t4_new_req");
        check("new_base", {2'b0, mem_addr}, 32'h555);
        check("new_empty", {24'b0, disp_data}, 32'h0);

        // 5: underrun with acks withheld
        ack_on = 0; base_addr = 30'h40;
        vs_pulse();
        rd = 1'b1;
        tick();
        rd = 1'b0;
        check("underrun_set",  {31'b0, underrun},  32'h1);
        check("underrun_disp", {24'b0, disp_data}, 32'h0);
        vs_pulse();
        check("underrun_clr", {31'b0, underrun}, 32'h0);
        ack_on = 1;

        // 6: reset mid-request
        wait_strobe(1'b0, "t6_wait_low");
        wait_strobe(1'b1, "t6_wait_high");
        reset = 1'b1;
        tick();
        check("midrst_strobe", {31'b0, mem_strobe}, 32'h0);
        check("midrst_addr",   {2'b0, mem_addr},    32'h0);
        check("midrst_disp",   {24'b0, disp_data},  32'h0);
        check("midrst_und",    {31'b0, underrun},   32'h0);
        reset = 1'b0; enable = 1'b0; rd = 1'b1;
        tick();
        rd = 1'b0;
        check("midrst_empty", {31'b0, underrun}, 32'h1);

        // random traffic
        data_fixed = 0; vs_low = 0;
        for (int c = 0; c < 6000; c++) begin
            enable = ($urandom_range(0, 7) != 0);
            rd     = ($urandom_range(0, 2) == 0);
            ack_on = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 63) == 0) ack_dly = $urandom_range(0, 4);
            if (vs_low > 0) begin
                vs_low--;
                if (vs_low == 0) vsync_n = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                vsync_n   = 1'b0;
                vs_low    = $urandom_range(1, 6);
                base_addr = ($urandom_range(0, 1) == 1) ? 30'h3FFF_FFF8 : AW'($urandom);
            end
            reset = ($urandom_range(0, 999) == 0);
            tick();
        end
        reset = 1'b0; rd = 1'b0; ack_on = 1; vsync_n = 1'b1;
        repeat (10) tick();
        cmp_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
